// File: rtl/hs_rr_arbiter_if.sv
// Handshake bundle for hs_rr_arbiter: NUM_CH request channels merged into one
// output stream. The slave modport is the arbiter's view; master is the
// environment's view (drives requests and the downstream ready).
interface hs_rr_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        i_valid;
  logic [NUM_CH-1:0]        o_ready;
  logic [NUM_CH*DATA_W-1:0] i_data;
  logic                     o_valid;
  logic                     i_ready;
  logic [DATA_W-1:0]        o_data;
  logic [CH_W-1:0]          o_ch;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_ch
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_ch
  );
endinterface

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin merge of NUM_CH valid/ready channels into one
// registered output stage. Grant is chosen combinationally each cycle starting
// one past the last granted channel.
// Optional feature: define HS_ARB_STATS_EN to add the saturating 16-bit
// output transfer counter o_xfer_cnt.
module hs_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rstn,
`ifdef HS_ARB_STATS_EN
  output logic [15:0]         o_xfer_cnt,
`endif
  hs_rr_arbiter_if.slave      bus
);

  localparam int unsigned CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic                o_valid_q, o_valid_d;
  logic [DATA_W-1:0]   o_data_q,  o_data_d;
  logic [CH_W-1:0]     o_ch_q,    o_ch_d;
  logic [CH_W-1:0]     ptr_q,     ptr_d;

  logic                ld_c;
  logic                grant_vld_c;
  logic [CH_W-1:0]     grant_idx_c;
  logic [DATA_W-1:0]   grant_data_c;
  logic [CH_W-1:0]     scan_idx_c;
  logic [NUM_CH-1:0]   ready_c;

  // Output stage may load when empty or when the slave is taking the current word
  assign ld_c = !o_valid_q || bus.i_ready;

  // Round-robin search: first valid channel at ptr+1, ptr+2, ... wrapping
  always_comb begin
    grant_vld_c  = 1'b0;
    grant_idx_c  = '0;
    grant_data_c = '0;
    scan_idx_c   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      scan_idx_c = CH_W'((32'(ptr_q) + k) % NUM_CH);
      if (!grant_vld_c && bus.i_valid[scan_idx_c]) begin
        grant_vld_c  = 1'b1;
        grant_idx_c  = scan_idx_c;
        grant_data_c = bus.i_data[32'(scan_idx_c)*DATA_W +: DATA_W];
      end
    end
  end

  // Accept only the granted channel, and only when the output stage can load;
  // nothing is accepted while reset is asserted
  always_comb begin
    ready_c = '0;
    if (i_rstn && ld_c && grant_vld_c) begin
      ready_c[grant_idx_c] = 1'b1;
    end
  end

  assign bus.o_ready = ready_c;

  // Output stage and pointer next-state
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_ch_d    = o_ch_q;
    ptr_d     = ptr_q;
    if (ld_c) begin
      if (grant_vld_c) begin
        o_valid_d = 1'b1;
        o_data_d  = grant_data_c;
        o_ch_d    = grant_idx_c;
        ptr_d     = grant_idx_c;
      end else begin
        o_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset leaves ptr at the last channel so channel 0 wins first
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_ch_q    <= '0;
      ptr_q     <= CH_W'(NUM_CH - 1);
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_ch_q    <= o_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_ch    = o_ch_q;

`ifdef HS_ARB_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Count completed output handshakes, saturating at all-ones
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (o_valid_q && bus.i_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  // Transfer counter register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_hs_rr_arbiter;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rstn;
`ifdef HS_ARB_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  hs_rr_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  hs_rr_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
`ifdef HS_ARB_STATS_EN
    .o_xfer_cnt (xfer_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Driven stimulus (the model reads these, never the DUT)
  logic [NUM_CH-1:0]        v_valid;
  logic [NUM_CH*DATA_W-1:0] v_data;
  logic                     v_ready;
  logic                     v_rstn;

  // Model: last granted channel, contents of the output register, transfer count
  int          m_ptr   = NUM_CH - 1;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [1:0]  m_ch    = '0;
  int          m_cnt   = 0;

  function automatic int model_grant();
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (v_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    logic [3:0] r;
    r = '0;
    g = model_grant();
    if (v_rstn && (!m_valid || v_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic [3:0] vl, input logic [127:0] d,
                       input logic rdy, input logic rs);
    v_valid = vl; v_data = d; v_ready = rdy; v_rstn = rs;
    bus.i_valid = vl; bus.i_data = d; bus.i_ready = rdy; rstn = rs;
    #1;
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    if (!v_rstn) begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = NUM_CH - 1; m_cnt = 0;
    end else begin
      g = model_grant();
      if (m_valid && v_ready && m_cnt < 65535) m_cnt++;
      if (!m_valid || v_ready) begin
        if (g >= 0) begin
          m_valid = 1'b1; m_data = v_data[g*DATA_W +: DATA_W]; m_ch = 2'(g); m_ptr = g;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] tag_data();
    return {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
  endfunction

  task automatic test_reset();
    drive(4'hF, rnd_data(), 1'b1, 1'b0);
    tick();
    tick();
    tests_run++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_o_valid got %b exp 0", bus.o_valid); end
    tests_run++; if (bus.o_data !== 32'h0) begin fails++; $display("FAIL reset_o_data got %h exp 0", bus.o_data); end
    tests_run++; if (bus.o_ch !== 2'd0) begin fails++; $display("FAIL reset_o_ch got %0d exp 0", bus.o_ch); end
    tests_run++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL reset_o_ready got %b exp 0000", bus.o_ready); end
`ifdef HS_ARB_STATS_EN
    tests_run++; if (xfer_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnt got %h exp 0", xfer_cnt); end
`endif
    drive(4'h0, rnd_data(), 1'b1, 1'b1);
    tests_run++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL idle_o_ready got %b exp 0000", bus.o_ready); end
    tick();
    tests_run++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL idle_o_valid got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_rr_all();
    drive(4'hF, tag_data(), 1'b1, 1'b1);
    tests_run++; if (bus.o_ready !== 4'b0001) begin fails++; $display("FAIL rr_first_ready got %b exp 0001", bus.o_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL rr_o_valid[%0d] got %b exp 1", i, bus.o_valid); end
      tests_run++; if (bus.o_ch !== 2'(i % 4)) begin fails++; $display("FAIL rr_o_ch[%0d] got %0d exp %0d", i, bus.o_ch, i % 4); end
      tests_run++; if (bus.o_data !== 32'hA5A5_0000 + 32'(i % 4)) begin fails++; $display("FAIL rr_o_data[%0d] got %h exp %h", i, bus.o_data, 32'hA5A5_0000 + 32'(i % 4)); end
    end
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = rnd_data();
    d[2*DATA_W +: DATA_W] = 32'hA5A5_0002;
    drive(4'b0100, d, 1'b1, 1'b1);
    tests_run++; if (bus.o_ready !== 4'b0100) begin fails++; $display("FAIL single_o_ready got %b exp 0100", bus.o_ready); end
    tick();
    tests_run++; if (bus.o_data !== 32'hA5A5_0002) begin fails++; $display("FAIL single_o_data got %h exp a5a50002", bus.o_data); end
    tests_run++; if (bus.o_ch !== 2'd2) begin fails++; $display("FAIL single_o_ch got %0d exp 2", bus.o_ch); end
  endtask

  task automatic test_stall();
    logic [31:0] sd;
    logic [1:0]  sc;
    sd = bus.o_data === m_data ? m_data : m_data;
    sc = m_ch;
    for (int i = 0; i < 3; i++) begin
      drive(4'(($urandom % 15) + 1), rnd_data(), 1'b0, 1'b1);
      tests_run++; if (bus.o_ready !== 4'b0000) begin fails++; $display("FAIL stall_o_ready[%0d] got %b exp 0000", i, bus.o_ready); end
      tests_run++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL stall_o_valid[%0d] got %b exp 1", i, bus.o_valid); end
      tests_run++; if (bus.o_data !== sd) begin fails++; $display("FAIL stall_o_data[%0d] got %h exp %h", i, bus.o_data, sd); end
      tests_run++; if (bus.o_ch !== sc) begin fails++; $display("FAIL stall_o_ch[%0d] got %0d exp %0d", i, bus.o_ch, sc); end
      tick();
    end
    tests_run++; if (bus.o_data !== sd || bus.o_ch !== sc) begin fails++; $display("FAIL stall_hold_end got %h/%0d exp %h/%0d", bus.o_data, bus.o_ch, sd, sc); end
    drive(4'hF, tag_data(), 1'b1, 1'b1);
    tests_run++; if (bus.o_ready !== 4'(1 << ((sc + 1) % 4))) begin fails++; $display("FAIL stall_release_ready got %b exp %b", bus.o_ready, 4'(1 << ((sc + 1) % 4))); end
    tick();
    tests_run++; if (bus.o_ch !== 2'(sc + 2'd1)) begin fails++; $display("FAIL stall_next_ch got %0d exp %0d", bus.o_ch, 2'(sc + 2'd1)); end
  endtask

  task automatic test_wrap();
    drive(4'b1000, tag_data(), 1'b1, 1'b1);
    tick();
    tests_run++; if (bus.o_ch !== 2'd3) begin fails++; $display("FAIL wrap_setup_ch got %0d exp 3", bus.o_ch); end
    drive(4'b1001, tag_data(), 1'b1, 1'b1);
    tests_run++; if (bus.o_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready0 got %b exp 0001", bus.o_ready); end
    tick();
    tests_run++; if (bus.o_ch !== 2'd0) begin fails++; $display("FAIL wrap_ch0 got %0d exp 0", bus.o_ch); end
    tests_run++; if (bus.o_ready !== 4'b1000) begin fails++; $display("FAIL wrap_ready3 got %b exp 1000", bus.o_ready); end
    tick();
    tests_run++; if (bus.o_ch !== 2'd3) begin fails++; $display("FAIL wrap_ch3 got %0d exp 3", bus.o_ch); end
  endtask

  task automatic test_reset_stall();
    drive(4'hF, tag_data(), 1'b1, 1'b1);
    tick();
    drive(4'hF, tag_data(), 1'b0, 1'b1);
    tick();
    tests_run++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL rststall_pre_valid got %b exp 1", bus.o_valid); end
    drive(4'hF, tag_data(), 1'b0, 1'b0);
    tick();
    tests_run++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rststall_valid got %b exp 0", bus.o_valid); end
    drive(4'hF, tag_data(), 1'b1, 1'b1);
    tests_run++; if (bus.o_ready !== 4'b0001) begin fails++; $display("FAIL rststall_ready got %b exp 0001", bus.o_ready); end
    tick();
    tests_run++; if (bus.o_ch !== 2'd0 || bus.o_valid !== 1'b1) begin fails++; $display("FAIL rststall_first got ch%0d v%b exp ch0 v1", bus.o_ch, bus.o_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] vl;
      vl = ($urandom % 3 == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      drive(vl, rnd_data(), ($urandom % 4) != 0, ($urandom % 150) != 0);
      tests_run++; if (bus.o_ready !== exp_ready()) begin fails++; $display("FAIL rand_o_ready[%0d] got %b exp %b", i, bus.o_ready, exp_ready()); end
      tests_run++; if (bus.o_valid !== m_valid) begin fails++; $display("FAIL rand_o_valid[%0d] got %b exp %b", i, bus.o_valid, m_valid); end
      tests_run++; if (bus.o_data !== m_data) begin fails++; $display("FAIL rand_o_data[%0d] got %h exp %h", i, bus.o_data, m_data); end
      tests_run++; if (bus.o_ch !== m_ch) begin fails++; $display("FAIL rand_o_ch[%0d] got %0d exp %0d", i, bus.o_ch, m_ch); end
`ifdef HS_ARB_STATS_EN
      tests_run++; if (xfer_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, xfer_cnt, m_cnt); end
`endif
      tick();
    end
  endtask

`ifdef HS_ARB_STATS_EN
  task automatic test_stats();
    drive(4'h0, rnd_data(), 1'b1, 1'b0);
    tick();
    tests_run++; if (xfer_cnt !== 16'h0) begin fails++; $display("FAIL stats_reset got %h exp 0", xfer_cnt); end
    drive(4'hF, rnd_data(), 1'b1, 1'b1);
    for (int i = 0; i < 70001; i++) begin
      if (i == 1000) begin
        tests_run++; if (xfer_cnt !== 16'(m_cnt)) begin fails++; $display("FAIL stats_mid got %0d exp %0d", xfer_cnt, m_cnt); end
      end
      tick();
    end
    tests_run++; if (xfer_cnt !== 16'hFFFF) begin fails++; $display("FAIL stats_sat got %h exp ffff", xfer_cnt); end
    for (int i = 0; i < 5; i++) tick();
    tests_run++; if (xfer_cnt !== 16'hFFFF) begin fails++; $display("FAIL stats_hold got %h exp ffff", xfer_cnt); end
  endtask
`endif

  initial begin
    v_valid = '0; v_data = '0; v_ready = 1'b0; v_rstn = 1'b0;
    bus.i_valid = '0; bus.i_data = '0; bus.i_ready = 1'b0; rstn = 1'b0;
    @(negedge clk);
    test_reset();
    test_rr_all();
    test_single();
    test_stall();
    test_wrap();
    test_reset_stall();
    test_random();
`ifdef HS_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
